// File: rtl/long_mem_arbiter.sv
// Two-requester arbiter sharing one line-wide memory port, with round-robin grant held for a whole transaction.
// Define LONG_ARB_FIXED_PRIO_EN to make requester 0 always win contention (no round-robin pointer).
module long_mem_arbiter #(
    parameter int LINE_BYTES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_read_en,
    input  logic                    req0_write_en,
    input  logic [31:0]             req0_addr,
    input  logic [8*LINE_BYTES-1:0] req0_data_i,
    input  logic [LINE_BYTES-1:0]   req0_data_en,
    output logic [8*LINE_BYTES-1:0] req0_data_o,
    output logic                    req0_hit,
    output logic                    req0_done,
    input  logic                    req1_read_en,
    input  logic                    req1_write_en,
    input  logic [31:0]             req1_addr,
    input  logic [8*LINE_BYTES-1:0] req1_data_i,
    input  logic [LINE_BYTES-1:0]   req1_data_en,
    output logic [8*LINE_BYTES-1:0] req1_data_o,
    output logic                    req1_hit,
    output logic                    req1_done,
    output logic                    mem_read_en,
    output logic                    mem_write_en,
    output logic [31:0]             mem_addr,
    output logic [8*LINE_BYTES-1:0] mem_data_i,
    output logic [LINE_BYTES-1:0]   mem_data_en,
    input  logic [8*LINE_BYTES-1:0] mem_data_o,
    input  logic                    mem_hit,
    input  logic                    mem_done
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   rr_next;
    logic   pend0;
    logic   pend1;

    assign pend0 = req0_read_en | req0_write_en;
    assign pend1 = req1_read_en | req1_write_en;

`ifdef LONG_ARB_FIXED_PRIO_EN
    assign rr_next = 1'b0;
`endif

    // RELEASE spans the downstream done cycle so the coupler is never re-triggered mid-transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
`ifndef LONG_ARB_FIXED_PRIO_EN
            rr_next <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pend0 | pend1) begin
                        state <= GRANT;
                        owner <= (pend0 & pend1) ? rr_next : pend1;
                    end
                end
                GRANT: begin
                    if (mem_hit) begin
                        state <= RELEASE;
`ifndef LONG_ARB_FIXED_PRIO_EN
                        rr_next <= ~owner;
`endif
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A simultaneous read and write from the owner is forwarded as a read only.
    always_comb begin
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_data_i   = '0;
        mem_data_en  = '0;
        if (state == GRANT) begin
            if (owner) begin
                mem_read_en  = req1_read_en;
                mem_write_en = req1_write_en & ~req1_read_en;
                mem_addr     = req1_addr;
                mem_data_i   = req1_data_i;
                mem_data_en  = req1_data_en;
            end else begin
                mem_read_en  = req0_read_en;
                mem_write_en = req0_write_en & ~req0_read_en;
                mem_addr     = req0_addr;
                mem_data_i   = req0_data_i;
                mem_data_en  = req0_data_en;
            end
        end
    end

    assign req0_hit  = mem_hit & (state == GRANT) & ~owner;
    assign req1_hit  = mem_hit & (state == GRANT) & owner;
    assign req0_done = mem_done & (state == RELEASE) & ~owner;
    assign req1_done = mem_done & (state == RELEASE) & owner;

    assign req0_data_o = mem_data_o;
    assign req1_data_o = mem_data_o;

endmodule

// File: tb/tb_long_mem_arbiter.sv
// Self-checking bench for long_mem_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_long_mem_arbiter;
    localparam int LB = 64;
    localparam int LW = 8 * LB;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            rd [2];
    logic            wr [2];
    logic [31:0]     addr [2];
    logic [LW-1:0]   dat [2];
    logic [LB-1:0]   en [2];
    logic [LW-1:0]   data_o0, data_o1;
    logic            hit0, hit1, done0, done1;
    logic            mem_read_en, mem_write_en;
    logic [31:0]     mem_addr;
    logic [LW-1:0]   mem_data_i;
    logic [LB-1:0]   mem_data_en;
    logic [LW-1:0]   mem_data_o = '0;
    logic            mem_hit = 1'b0;
    logic            mem_done = 1'b0;

    // transaction-level view of the arbiter: who holds the port and who wins the next tie
    bit m_busy = 0, m_rel = 0;
    int m_owner = 0, m_prefer = 0;

    // downstream memory model
    int ds_cnt = -1, ds_lat = 0;
    bit ds_done_next = 0, force_hit = 0;

    bit check_en = 0;
    int checks = 0, failures = 0;

    logic          o_rd, o_wr;
    logic [31:0]   o_addr;
    logic [LB-1:0] o_en;
    bit            o_hit [2];
    bit            o_done [2];

    long_mem_arbiter #(.LINE_BYTES(LB)) dut (
        .clk(clk), .reset(reset),
        .req0_read_en(rd[0]), .req0_write_en(wr[0]), .req0_addr(addr[0]),
        .req0_data_i(dat[0]), .req0_data_en(en[0]), .req0_data_o(data_o0),
        .req0_hit(hit0), .req0_done(done0),
        .req1_read_en(rd[1]), .req1_write_en(wr[1]), .req1_addr(addr[1]),
        .req1_data_i(dat[1]), .req1_data_en(en[1]), .req1_data_o(data_o1),
        .req1_hit(hit1), .req1_done(done1),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_data_i(mem_data_i), .mem_data_en(mem_data_en), .mem_data_o(mem_data_o),
        .mem_hit(mem_hit), .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic newReq(input int i);
        int op;
        op = $urandom_range(0, 2);
        rd[i] = (op != 1);
        wr[i] = (op != 0);
        addr[i] = $urandom & ~32'h3F;
        for (int k = 0; k < LW / 32; k++) dat[i][k*32 +: 32] = $urandom;
        en[i] = {$urandom, $urandom};
    endtask

    // One clock cycle: downstream reacts, outputs are compared with the model, then the model advances.
    task automatic applyStimulus();
        logic          e_rd, e_wr;
        logic [31:0]   e_addr;
        logic [LW-1:0] e_di;
        logic [LB-1:0] e_en;
        logic [1:0]    e_hit, e_done;
        bit            p0, p1;
        #1;
        if (ds_cnt < 0 && (mem_read_en || mem_write_en)) ds_cnt = ds_lat;
        mem_hit = (ds_cnt == 0) || force_hit;
        mem_done = ds_done_next;
        for (int k = 0; k < LW / 32; k++) mem_data_o[k*32 +: 32] = $urandom;
        #1;
        e_rd = 0; e_wr = 0; e_addr = '0; e_di = '0; e_en = '0; e_hit = '0; e_done = '0;
        if (m_busy) begin
            e_rd   = rd[m_owner];
            e_wr   = wr[m_owner] & ~rd[m_owner];
            e_addr = addr[m_owner];
            e_di   = dat[m_owner];
            e_en   = en[m_owner];
            e_hit[m_owner] = mem_hit;
        end
        if (m_rel) e_done[m_owner] = mem_done;
        if (check_en) begin
            checkOutput("mem_ctrl", {mem_read_en, mem_write_en}, {e_rd, e_wr});
            checkOutput("mem_addr", mem_addr, e_addr);
            checkOutput("mem_data_i", mem_data_i, e_di);
            checkOutput("mem_data_en", mem_data_en, e_en);
            checkOutput("req_hit", {hit1, hit0}, e_hit);
            checkOutput("req_done", {done1, done0}, e_done);
            checkOutput("data_o0", data_o0, mem_data_o);
            checkOutput("data_o1", data_o1, mem_data_o);
        end
        o_rd = mem_read_en; o_wr = mem_write_en; o_addr = mem_addr; o_en = mem_data_en;
        o_hit[0] = hit0; o_hit[1] = hit1; o_done[0] = done0; o_done[1] = done1;
        @(posedge clk);
        p0 = rd[0] | wr[0];
        p1 = rd[1] | wr[1];
        if (reset) begin
            m_busy = 0; m_rel = 0; m_owner = 0; m_prefer = 0;
            ds_cnt = -1; ds_done_next = 0;
        end else begin
            if (m_rel) m_rel = 0;
            else if (m_busy) begin
                if (mem_hit) begin
                    m_busy = 0;
                    m_rel = 1;
`ifndef LONG_ARB_FIXED_PRIO_EN
                    m_prefer = 1 - m_owner;
`endif
                end
            end else if (p0 || p1) begin
                m_busy = 1;
                m_owner = (p0 && p1) ? m_prefer : (p1 ? 1 : 0);
            end
            ds_done_next = mem_hit;
            if (ds_cnt == 0) ds_cnt = -1;
            else if (ds_cnt > 0) ds_cnt--;
        end
        @(negedge clk);
    endtask

    task automatic clearReqs();
        for (int i = 0; i < 2; i++) begin
            rd[i] = 0; wr[i] = 0; addr[i] = '0; dat[i] = '0; en[i] = '0;
        end
    endtask

    task automatic resetCycle();
        clearReqs();
        reset = 1;
        applyStimulus();
        reset = 0;
    endtask

    initial begin
        int n;
        bit found, busy_seen, act [2];
        int order [$];
        int exp_owner;
        clearReqs();
        applyStimulus();
        check_en = 1;
        reset = 0;

        // quiet after reset
        busy_seen = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus();
            busy_seen |= o_rd | o_wr | o_hit[0] | o_hit[1] | o_done[0] | o_done[1] | (o_addr != 0);
        end
        checkOutput("idle_quiet", busy_seen, 0);

        // single read with 5-cycle downstream latency
        rd[0] = 1; addr[0] = 32'h1000; ds_lat = 5;
        applyStimulus();
        checkOutput("t2_idle_rd", o_rd, 0);
        applyStimulus();
        checkOutput("t2_grant_rd", o_rd, 1);
        checkOutput("t2_grant_addr", o_addr, 32'h1000);
        found = 0; n = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            applyStimulus();
            if (o_hit[0]) begin found = 1; n = c; end
        end
        checkOutput("t2_hit_latency", n, 5);
        rd[0] = 0;
        applyStimulus();
        checkOutput("t2_done0", o_done[0], 1);

        // contention: alternation (or fixed priority)
        resetCycle();
        rd[0] = 1; addr[0] = 32'h2000;
        wr[1] = 1; addr[1] = 32'h3000; en[1] = '1; dat[1] = {16{32'hA5A5_5A5A}};
        ds_lat = 2;
        for (int c = 0; c < 100 && order.size() < 4; c++) begin
            applyStimulus();
            if (o_hit[0]) order.push_back(0);
            if (o_hit[1]) begin
                order.push_back(1);
                checkOutput("t3_req1_write", {o_rd, o_wr}, 2'b01);
                checkOutput("t3_req1_en", o_en, {LB{1'b1}});
            end
        end
        checkOutput("t3_served", order.size(), 4);
        for (int k = 0; k < 4 && k < order.size(); k++) begin
`ifdef LONG_ARB_FIXED_PRIO_EN
            exp_owner = 0;
`else
            exp_owner = k % 2;
`endif
            checkOutput($sformatf("t3_order%0d", k), order[k], exp_owner);
        end
        clearReqs();
        applyStimulus();
        applyStimulus();

        // sticky grant: req1 drops write_en mid-GRANT while req0 waits
        resetCycle();
        wr[1] = 1; addr[1] = 32'h4000; en[1] = 64'h0000_FFFF_0000_FFFF; dat[1] = {16{32'h1234_5678}};
        ds_lat = 6;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        wr[1] = 0;
        rd[0] = 1; addr[0] = 32'h5000;
        found = 0; busy_seen = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            applyStimulus();
            busy_seen |= o_hit[0] | o_rd;
            if (o_hit[1]) found = 1;
        end
        checkOutput("t4_hit1_seen", found, 1);
        checkOutput("t4_no_req0_grant", busy_seen, 0);
        applyStimulus();
        checkOutput("t4_done1", {o_done[1], o_done[0]}, 2'b10);
        applyStimulus();
        checkOutput("t4_idle_rd", o_rd, 0);
        applyStimulus();
        checkOutput("t4_req0_grant", {o_rd, o_addr}, {1'b1, 32'h5000});

        // reset in the middle of req0's GRANT
        ds_lat = 10;
        applyStimulus();
        reset = 1;
        applyStimulus();
        reset = 0;
        rd[0] = 0;
        applyStimulus();
        checkOutput("t5_after_reset", {o_rd, o_wr}, 2'b00);
        force_hit = 1;
        applyStimulus();
        force_hit = 0;
        checkOutput("t5_stray_hit", {o_hit[1], o_hit[0]}, 2'b00);
        applyStimulus();
        checkOutput("t5_stray_done", {o_done[1], o_done[0]}, 2'b00);

        // read+write together forwards read only; req0 wins the first tie after reset
        rd[0] = 1; wr[0] = 1; addr[0] = 32'h6000;
        rd[1] = 1; addr[1] = 32'h7000;
        ds_lat = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("t6_rw_forward", {o_rd, o_wr, o_addr}, {2'b10, 32'h6000});
        clearReqs();
        for (int c = 0; c < 6; c++) applyStimulus();

        // randomized traffic
        resetCycle();
        act[0] = 0; act[1] = 0;
        for (int c = 0; c < 600; c++) begin
            ds_lat = $urandom_range(0, 4);
            for (int i = 0; i < 2; i++)
                if (!act[i] && $urandom_range(0, 2) == 0) begin
                    newReq(i);
                    act[i] = 1;
                end
            applyStimulus();
            for (int i = 0; i < 2; i++)
                if (o_hit[i]) begin
                    if ($urandom_range(0, 1) == 1) newReq(i);
                    else begin
                        rd[i] = 0; wr[i] = 0; act[i] = 0;
                    end
                end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
